cluster_pwr_seq: RTL and testbench
==================================

# cluster_pwr_seq

Sequencer for the cluster control signals the SoC domain drives: power, clock bypass, clock enable, reset, boot address and fetch enable. It sits in the SoC domain between the SoC control registers (the command source) and the cluster interface outputs. It brings the cluster up and down in a fixed, timed order. On power-down it drains outstanding cluster activity, using `cluster_busy_i` with a timeout, before removing reset, clock and power.

## Interface

Parameters:
- `PWR_WAIT`, 16: cycles from `cluster_pow_o` rising to clock bypass release (≥1).
- `CLK_WAIT`, 4: cycles the clock runs with reset held, and cycles after clock gating before power-off (≥1).
- `RST_WAIT`, 8: cycles from reset release to `cluster_fetch_enable_o` (≥1).
- `BUSY_TIMEOUT`, 1024: maximum drain cycles waiting for `cluster_busy_i` low (≥1).
- Counter width is `$clog2(max of all four)+1`.

Ports:
- `clk_i`, in, 1: SoC clock.
- `rst_ni`, in, 1: asynchronous active-low reset.
- `pwr_up_i`, in, 1: single-cycle power-up command.
- `pwr_dn_i`, in, 1: single-cycle power-down command.
- `boot_addr_i`, in, 64: boot address; sampled when `pwr_up_i` is accepted.
- `cluster_busy_i`, in, 1: cluster activity indicator.
- `cluster_pow_o`, out, 1: cluster power switch enable.
- `cluster_byp_o`, out, 1: cluster clock bypass (1 = bypass).
- `cluster_clk_en_o`, out, 1: cluster clock gate enable.
- `cluster_rstn_o`, out, 1: cluster reset, active-low.
- `cluster_fetch_enable_o`, out, 1: cluster core fetch enable.
- `cluster_boot_addr_o`, out, 64: latched boot address.
- `done_o`, out, 1: one-cycle pulse when the OFF or ON state is reached.
- `timeout_o`, out, 1: sticky flag, set when a drain timed out.
- `state_o`, out, 3: current state encoding, for status registers.

## Operation

States and their encodings:
- OFF = 0, PWR = 1, CLK = 2, RST = 3, ON = 4, DRAIN = 5, GATE = 6, DOWN = 7.

Output values per state, in the order pow / byp / clk_en / rstn / fetch:

| State | pow | byp | clk_en | rstn | fetch |
|---|---|---|---|---|---|
| OFF | 0 | 1 | 0 | 0 | 0 |
| PWR | 1 | 1 | 0 | 0 | 0 |
| CLK | 1 | 0 | 1 | 0 | 0 |
| RST | 1 | 0 | 1 | 1 | 0 |
| ON | 1 | 0 | 1 | 1 | 1 |
| DRAIN | 1 | 0 | 1 | 1 | 0 |
| GATE | 1 | 0 | 0 | 0 | 0 |
| DOWN | 1 | 1 | 0 | 0 | 0 |

- All outputs are registered, decoded from the state register (Moore).

Transitions:
- OFF → PWR on `pwr_up_i`. `boot_addr_i` is latched into `cluster_boot_addr_o` and `timeout_o` is cleared.
- PWR → CLK after `PWR_WAIT` cycles.
- CLK → RST after `CLK_WAIT` cycles.
- RST → ON after `RST_WAIT` cycles.
- ON → DRAIN on `pwr_dn_i`.
- DRAIN → GATE when `cluster_busy_i` is 0 for one sampled cycle, or when `BUSY_TIMEOUT` cycles elapse. A timeout sets `timeout_o`.
- GATE → DOWN after `CLK_WAIT` cycles.
- DOWN → OFF after 1 cycle.
- `done_o` pulses in the first cycle of ON and in the first cycle of OFF, except the OFF entered via reset.

Command rules:
- `pwr_up_i` is accepted only in OFF.
- `pwr_dn_i` is accepted only in ON.
- Commands arriving in any other state are dropped, with no queuing.
- `pwr_up_i` and `pwr_dn_i` asserted in the same cycle: only the command valid for the current state takes effect.
- `pwr_dn_i` during a power-up ramp is dropped. Software must wait for `done_o`.

Timed-state counter:
- Loaded with N−1 on state entry; the state exits when the counter is 0.
- A state with wait N therefore lasts exactly N cycles.
- In DRAIN the counter is loaded with `BUSY_TIMEOUT`−1.

Reset:
- The asynchronous reset, at any time including mid-sequence, forces OFF immediately.
- All outputs take their OFF values; `cluster_boot_addr_o` = 0, `timeout_o` = 0, `done_o` = 0, `state_o` = 0.

## Timing

- `pwr_up_i` high at cycle T (in OFF):
  - `cluster_pow_o` = 1 at T+1.
  - byp = 0 and `cluster_clk_en_o` = 1 at T+1+`PWR_WAIT`.
  - `cluster_rstn_o` = 1 at T+1+`PWR_WAIT`+`CLK_WAIT`.
  - `cluster_fetch_enable_o` = 1 and `done_o` at T+1+`PWR_WAIT`+`CLK_WAIT`+`RST_WAIT`.
  - With defaults: T+1, T+17, T+21, T+29.
- `pwr_dn_i` at T (in ON):
  - fetch = 0 at T+1.
  - If busy is already 0 at T+1: `cluster_clk_en_o`/rstn = 0 at T+2, byp = 1 at T+2+`CLK_WAIT`, pow = 0 and `done_o` at T+3+`CLK_WAIT`.
- Drain timing:
  - Busy is sampled every DRAIN cycle, including the first.
  - The exit occurs in the cycle after busy is first seen low.
  - Timeout exit occurs after exactly `BUSY_TIMEOUT` DRAIN cycles.
- Command latency: a command is not seen earlier than the cycle after it is asserted; no combinational paths from inputs to outputs.

## Test plan

- **Reset values:** assert `rst_ni` = 0 mid-PWR → next evaluation shows all outputs at OFF values, `state_o` = 0, no `done_o`.
- **Power-up, defaults:** `boot_addr_i` = 0x1C00_8080 with `pwr_up_i` at cycle 10 → pow=1 @11, byp=0 and clk_en=1 @27, rstn=1 @31, fetch=1 and `done_o` @39, `cluster_boot_addr_o` = 0x1C00_8080 from 11.
- **Power-down, idle cluster:** busy=0, `pwr_dn_i` @100 → fetch=0 @101, clk_en=0 and rstn=0 @102, byp=1 @106, pow=0 and `done_o` @107, `timeout_o` = 0.
- **Drain wait and timeout:**
  - busy held high for 50 cycles after `pwr_dn_i` → GATE entered the cycle after busy drops, `timeout_o` = 0.
  - busy held high forever → GATE after 1024 DRAIN cycles, `timeout_o` = 1 and sticky until the next accepted `pwr_up_i`.
- **Illegal and simultaneous commands:**
  - `pwr_dn_i` during PWR/CLK/RST → ignored; ON is still reached at the nominal cycle.
  - `pwr_up_i` in ON → ignored.
  - Both commands in OFF → power-up starts.
  - `boot_addr_i` changed after acceptance → `cluster_boot_addr_o` unchanged.
- **Parameter sweep:** all wait parameters = 1 → each timed state lasts exactly 1 cycle; up sequence completes in 4 cycles.

Source files
------------

// File: rtl/cluster_pwr_seq.sv
// Cluster power sequencer: timed power/clock/reset bring-up and busy-drained
// power-down of the cluster control signals, with Moore-registered outputs.
module cluster_pwr_seq #(
    parameter int unsigned PWR_WAIT     = 16,
    parameter int unsigned CLK_WAIT     = 4,
    parameter int unsigned RST_WAIT     = 8,
    parameter int unsigned BUSY_TIMEOUT = 1024
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        pwr_up_i,
    input  logic        pwr_dn_i,
    input  logic [63:0] boot_addr_i,
    input  logic        cluster_busy_i,
    output logic        cluster_pow_o,
    output logic        cluster_byp_o,
    output logic        cluster_clk_en_o,
    output logic        cluster_rstn_o,
    output logic        cluster_fetch_enable_o,
    output logic [63:0] cluster_boot_addr_o,
    output logic        done_o,
    output logic        timeout_o,
    output logic [2:0]  state_o
);

    localparam int unsigned MAX_PC  = (PWR_WAIT > CLK_WAIT) ? PWR_WAIT : CLK_WAIT;
    localparam int unsigned MAX_RB  = (RST_WAIT > BUSY_TIMEOUT) ? RST_WAIT : BUSY_TIMEOUT;
    localparam int unsigned MAX_ALL = (MAX_PC > MAX_RB) ? MAX_PC : MAX_RB;
    localparam int unsigned CNT_W   = $clog2(MAX_ALL) + 1;

    // A timed state with wait N is entered with N-1 and leaves when the count is 0.
    localparam logic [CNT_W-1:0] PWR_LOAD = CNT_W'(PWR_WAIT - 1);
    localparam logic [CNT_W-1:0] CLK_LOAD = CNT_W'(CLK_WAIT - 1);
    localparam logic [CNT_W-1:0] RST_LOAD = CNT_W'(RST_WAIT - 1);
    localparam logic [CNT_W-1:0] TMO_LOAD = CNT_W'(BUSY_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [2:0] {
        S_OFF   = 3'd0,
        S_PWR   = 3'd1,
        S_CLK   = 3'd2,
        S_RST   = 3'd3,
        S_ON    = 3'd4,
        S_DRAIN = 3'd5,
        S_GATE  = 3'd6,
        S_DOWN  = 3'd7
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tmo_set;
    logic [4:0]       outs_q;
    logic [63:0]      addr_q;
    logic             done_q;
    logic             tmo_q;

    // Output vector order: pow, byp, clk_en, rstn, fetch.
    function automatic logic [4:0] decode(input state_e s);
        logic [4:0] v;
        v = 5'b01000;
        case (s)
            S_OFF:   v = 5'b01000;
            S_PWR:   v = 5'b11000;
            S_CLK:   v = 5'b10100;
            S_RST:   v = 5'b10110;
            S_ON:    v = 5'b10111;
            S_DRAIN: v = 5'b10110;
            S_GATE:  v = 5'b10000;
            S_DOWN:  v = 5'b11000;
            default: v = 5'b01000;
        endcase
        return v;
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tmo_set = 1'b0;
        case (state_q)
            S_OFF: begin
                if (pwr_up_i) begin
                    state_d = S_PWR;
                    cnt_d   = PWR_LOAD;
                end
            end
            S_PWR: begin
                if (cnt_q == '0) begin
                    state_d = S_CLK;
                    cnt_d   = CLK_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_CLK: begin
                if (cnt_q == '0) begin
                    state_d = S_RST;
                    cnt_d   = RST_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_RST: begin
                if (cnt_q == '0) begin
                    state_d = S_ON;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_ON: begin
                if (pwr_dn_i) begin
                    state_d = S_DRAIN;
                    cnt_d   = TMO_LOAD;
                end
            end
            S_DRAIN: begin
                // An idle cluster wins over an expiring timeout in the same cycle.
                if (!cluster_busy_i) begin
                    state_d = S_GATE;
                    cnt_d   = CLK_LOAD;
                end else if (cnt_q == '0) begin
                    state_d = S_GATE;
                    cnt_d   = CLK_LOAD;
                    tmo_set = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_GATE: begin
                if (cnt_q == '0) begin
                    state_d = S_DOWN;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_DOWN: begin
                state_d = S_OFF;
            end
            default: begin
                state_d = S_OFF;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_OFF;
            cnt_q   <= '0;
            outs_q  <= 5'b01000;
            addr_q  <= '0;
            done_q  <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            outs_q  <= decode(state_d);
            done_q  <= (state_d != state_q) && ((state_d == S_ON) || (state_d == S_OFF));
            if ((state_q == S_OFF) && pwr_up_i) begin
                addr_q <= boot_addr_i;
                tmo_q  <= 1'b0;
            end else if (tmo_set) begin
                tmo_q <= 1'b1;
            end
        end
    end

    assign cluster_pow_o          = outs_q[4];
    assign cluster_byp_o          = outs_q[3];
    assign cluster_clk_en_o       = outs_q[2];
    assign cluster_rstn_o         = outs_q[1];
    assign cluster_fetch_enable_o = outs_q[0];
    assign cluster_boot_addr_o    = addr_q;
    assign done_o                 = done_q;
    assign timeout_o              = tmo_q;
    assign state_o                = state_q;

endmodule

// File: tb/tb_cluster_pwr_seq.sv
// Randomized bench for cluster_pwr_seq: expected state/outputs are derived
// from the command time and the documented wait lengths with plain arithmetic.
module tb_cluster_pwr_seq;

    localparam int P  = 16;
    localparam int C  = 4;
    localparam int R  = 8;
    localparam int TO = 1024;

    // Expected pow/byp/clk_en/rstn/fetch per state encoding
    localparam logic [4:0] OUT_TBL [0:7] = '{5'b01000, 5'b11000, 5'b10100, 5'b10110,
                                             5'b10111, 5'b10110, 5'b10000, 5'b11000};

    logic        clk;
    logic        rst_n;
    logic        pwr_up_i, pwr_dn_i, busy;
    logic [63:0] boot_addr_i;
    logic        pow, byp, clk_en, rstn, fetch, done, tmo;
    logic [63:0] addr_o;
    logic [2:0]  state_o;

    logic        up2, dn2, busy2;
    logic        pow2, byp2, clk_en2, rstn2, fetch2, done2, tmo2;
    logic [63:0] addr2;
    logic [2:0]  state2;

    int          total;
    int          bad;
    logic [63:0] exp_addr;
    bit          tmo_m;

    cluster_pwr_seq #(
        .PWR_WAIT(P), .CLK_WAIT(C), .RST_WAIT(R), .BUSY_TIMEOUT(TO)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .pwr_up_i(pwr_up_i), .pwr_dn_i(pwr_dn_i),
        .boot_addr_i(boot_addr_i), .cluster_busy_i(busy),
        .cluster_pow_o(pow), .cluster_byp_o(byp), .cluster_clk_en_o(clk_en),
        .cluster_rstn_o(rstn), .cluster_fetch_enable_o(fetch),
        .cluster_boot_addr_o(addr_o), .done_o(done), .timeout_o(tmo), .state_o(state_o)
    );

    cluster_pwr_seq #(
        .PWR_WAIT(1), .CLK_WAIT(1), .RST_WAIT(1), .BUSY_TIMEOUT(2)
    ) dut_min (
        .clk_i(clk), .rst_ni(rst_n), .pwr_up_i(up2), .pwr_dn_i(dn2),
        .boot_addr_i(64'h0000_0000_0000_0042), .cluster_busy_i(busy2),
        .cluster_pow_o(pow2), .cluster_byp_o(byp2), .cluster_clk_en_o(clk_en2),
        .cluster_rstn_o(rstn2), .cluster_fetch_enable_o(fetch2),
        .cluster_boot_addr_o(addr2), .done_o(done2), .timeout_o(tmo2), .state_o(state2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [73:0] expv(input int st, input bit dn, input bit tm,
                                         input logic [63:0] a);
        return {3'(st), OUT_TBL[st], dn, tm, a};
    endfunction

    function automatic logic [73:0] actv();
        return {state_o, pow, byp, clk_en, rstn, fetch, done, tmo, addr_o};
    endfunction

    task automatic test_reset();
        logic [73:0] e;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        e = expv(0, 0, 0, 64'h0);
        total++;
        if (actv() !== e) begin
            bad++;
            $display("FAIL reset_values: got %h expected %h", actv(), e);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_addr = '0;
        tmo_m = 0;
    endtask

    // Power-up from OFF; 'both' also raises pwr_dn_i with the command, 'noise'
    // throws ignored commands and boot address changes during the ramp.
    task automatic test_power_up(input logic [63:0] addr, input bit both, input bit noise);
        int n;
        int st;
        logic [73:0] e;
        n = P + C + R + 1;
        @(posedge clk); #1;
        pwr_up_i = 1'b1;
        pwr_dn_i = both;
        boot_addr_i = addr;
        exp_addr = addr;
        tmo_m = 0;
        for (int o = 1; o <= n; o++) begin
            @(posedge clk); #1;
            pwr_up_i = (noise && o < n) ? 1'($urandom_range(0, 1)) : 1'b0;
            pwr_dn_i = (noise && o < n) ? 1'($urandom_range(0, 1)) : 1'b0;
            boot_addr_i = {$urandom, $urandom};
            busy = 1'($urandom_range(0, 1));
            @(negedge clk);
            st = (o <= P) ? 1 : (o <= P + C) ? 2 : (o <= P + C + R) ? 3 : 4;
            e = expv(st, o == n, 0, exp_addr);
            total++;
            if (actv() !== e) begin
                bad++;
                $display("FAIL power_up off=%0d: got %h expected %h", o, actv(), e);
            end
        end
    endtask

    // Power-down from ON; busy stays high for the first k DRAIN cycles.
    task automatic test_power_down(input int k, input bit noise);
        int d, n, st;
        bit tmo_new;
        logic [73:0] e;
        d = (k + 1 < TO) ? k + 1 : TO;
        tmo_new = (k >= TO);
        n = d + C + 2;
        @(posedge clk); #1;
        pwr_dn_i = 1'b1;
        pwr_up_i = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        busy = 1'b1;
        for (int o = 1; o <= n; o++) begin
            @(posedge clk); #1;
            pwr_dn_i = (noise && o < n) ? 1'($urandom_range(0, 1)) : 1'b0;
            pwr_up_i = (noise && o < n) ? 1'($urandom_range(0, 1)) : 1'b0;
            busy = (o - 1 < k);
            @(negedge clk);
            st = (o <= d) ? 5 : (o <= d + C) ? 6 : (o == d + C + 1) ? 7 : 0;
            if (o == d + 1 && tmo_new) tmo_m = 1;
            e = expv(st, o == n, tmo_m, exp_addr);
            total++;
            if (actv() !== e) begin
                bad++;
                $display("FAIL power_down k=%0d off=%0d: got %h expected %h", k, o, actv(), e);
            end
        end
    endtask

    task automatic test_up_in_on(input int cycles);
        logic [73:0] e;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            pwr_up_i = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            boot_addr_i = {$urandom, $urandom};
            @(negedge clk);
            e = expv(4, 0, tmo_m, exp_addr);
            total++;
            if (actv() !== e) begin
                bad++;
                $display("FAIL up_in_on cyc=%0d: got %h expected %h", i, actv(), e);
            end
        end
        @(posedge clk); #1;
        pwr_up_i = 1'b0;
        @(negedge clk);
        e = expv(4, 0, tmo_m, exp_addr);
        total++;
        if (actv() !== e) begin
            bad++;
            $display("FAIL up_in_on settle: got %h expected %h", actv(), e);
        end
    endtask

    task automatic test_idle_off(input int cycles);
        logic [73:0] e;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            pwr_dn_i = 1'($urandom_range(0, 1));
            busy = 1'($urandom_range(0, 1));
            @(negedge clk);
            e = expv(0, 0, tmo_m, exp_addr);
            total++;
            if (actv() !== e) begin
                bad++;
                $display("FAIL idle_off cyc=%0d: got %h expected %h", i, actv(), e);
            end
        end
        @(posedge clk); #1;
        pwr_dn_i = 1'b0;
    endtask

    task automatic test_timeout();
        test_power_up({$urandom, $urandom}, 0, 1);
        test_power_down(5000, 1);
        test_idle_off(6);
        test_power_up(64'hDEAD_BEEF_0000_1000, 1, 0);
        test_power_down(TO - 1, 0);
        test_power_up({$urandom, $urandom}, 0, 0);
        test_power_down(TO, 0);
        test_idle_off(3);
    endtask

    task automatic test_reset_mid();
        logic [73:0] e;
        @(posedge clk); #1;
        pwr_up_i = 1'b1;
        boot_addr_i = 64'h0123_4567_89AB_CDEF;
        @(posedge clk); #1;
        pwr_up_i = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        e = expv(0, 0, 0, 64'h0);
        total++;
        if (actv() !== e) begin
            bad++;
            $display("FAIL reset_mid_pwr: got %h expected %h", actv(), e);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_addr = '0;
        tmo_m = 0;
        @(negedge clk);
        total++;
        if (actv() !== e) begin
            bad++;
            $display("FAIL reset_release: got %h expected %h", actv(), e);
        end
    endtask

    task automatic test_param_sweep();
        int st;
        logic [3:0] e1, a1;
        logic [4:0] e2, a2;
        @(posedge clk); #1;
        up2 = 1'b1;
        for (int o = 1; o <= 4; o++) begin
            @(posedge clk); #1;
            up2 = 1'b0;
            @(negedge clk);
            e1 = {3'(o), o == 4};
            a1 = {state2, done2};
            total++;
            if (a1 !== e1) begin
                bad++;
                $display("FAIL sweep_up off=%0d: got %h expected %h", o, a1, e1);
            end
        end
        @(posedge clk); #1;
        dn2 = 1'b1;
        busy2 = 1'b1;
        for (int o = 1; o <= 5; o++) begin
            @(posedge clk); #1;
            dn2 = 1'b0;
            @(negedge clk);
            st = (o <= 2) ? 5 : (o == 3) ? 6 : (o == 4) ? 7 : 0;
            e2 = {3'(st), o == 5, o >= 3};
            a2 = {state2, done2, tmo2};
            total++;
            if (a2 !== e2) begin
                bad++;
                $display("FAIL sweep_down off=%0d: got %h expected %h", o, a2, e2);
            end
        end
    endtask

    task automatic test_back_to_back(input int rounds);
        for (int r = 0; r < rounds; r++) begin
            test_power_up({$urandom, $urandom}, 1'($urandom_range(0, 1)), 1);
            test_power_down(int'($urandom_range(0, 80)), 1);
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        pwr_up_i = 1'b0;
        pwr_dn_i = 1'b0;
        busy = 1'b0;
        boot_addr_i = '0;
        up2 = 1'b0;
        dn2 = 1'b0;
        busy2 = 1'b0;
        exp_addr = '0;
        tmo_m = 0;

        test_reset();
        test_power_up(64'h0000_0000_1C00_8080, 0, 1);
        test_up_in_on(5);
        test_power_down(0, 0);
        test_power_up({$urandom, $urandom}, 0, 1);
        test_power_down(50, 0);
        test_timeout();
        test_back_to_back(4);
        test_reset_mid();
        test_param_sweep();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
